// File: rtl/wb_uart_bridge_pkg.sv
// wb_uart_bridge_pkg: command/response byte codes, FSM states and response geometry
// shared by the UART-to-Wishbone bridge and its response shifter.
`default_nettype none

package wb_uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TO  = 8'h54;  // 'T'

  localparam int RSP_BYTES = 5;
  localparam int RSP_W     = 8 * RSP_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/wb_uart_bridge_rsp.sv
// ============================================================================
// wb_uart_bridge_rsp: up-to-5-byte response shifter, MSB byte first, valid/ready out.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_uart_bridge_rsp
  import wb_uart_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [RSP_W-1:0] load_data_i,
  input  logic [2:0]       load_cnt_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [2:0]       cnt_o
);

  logic [RSP_W-1:0] shreg_q;
  logic [2:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= 3'd0;
    end else if (load_i) begin
      shreg_q <= load_data_i;
      cnt_q   <= load_cnt_i;
    end else if ((cnt_q != 3'd0) && tx_ready_i) begin
      // Zero-fill so tx_data_o returns to 0 once the response is drained.
      shreg_q <= {shreg_q[RSP_W-9:0], 8'h00};
      cnt_q   <= cnt_q - 3'd1;
    end
  end

  assign tx_data_o  = shreg_q[RSP_W-1:RSP_W-8];
  assign tx_valid_o = (cnt_q != 3'd0);
  assign cnt_o      = cnt_q;

endmodule

`default_nettype wire

// File: rtl/wb_uart_bridge.sv
// ============================================================================
// wb_uart_bridge: UART byte stream to single Wishbone master cycles, with 'K'/'?'/'T'
// responses. Optional ack watchdog under WB_BRIDGE_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_uart_bridge
  import wb_uart_bridge_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_addr_o,
  output logic [DW-1:0]   wbm_wdata_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_rdata_i,
  input  logic            wbm_ack_i,
  output logic            busy_o
);

  state_e              state_q;
  logic                we_q;
  logic [1:0]          cnt_q;
  logic                cyc_q;
  logic                stb_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     sel_q;

  logic                rx_fire;
  logic                tx_last;
  logic                bus_ack;
  logic                tmo_hit;
  logic                rsp_load;
  logic [RSP_W-1:0]    rsp_data;
  logic [2:0]          rsp_cnt_ld;
  logic [2:0]          rsp_cnt;

  assign rx_ready_o = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_WDATA);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_last    = tx_valid_o && tx_ready_i && (rsp_cnt == 3'd1);
  assign bus_ack    = (state_q == ST_BUS) && wbm_ack_i;
  assign busy_o     = (state_q != ST_IDLE);

`ifdef WB_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_q;

  // An ack on the limit cycle takes priority over the timeout.
  assign tmo_hit = (state_q == ST_BUS) && !wbm_ack_i && (tmo_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_BUS)) begin
      tmo_q <= 8'd0;
    end else if (!wbm_ack_i) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    rsp_load   = 1'b0;
    rsp_data   = '0;
    rsp_cnt_ld = 3'd0;
    if ((state_q == ST_IDLE) && rx_fire && (rx_data_i != CMD_WR) && (rx_data_i != CMD_RD)) begin
      rsp_load   = 1'b1;
      rsp_data   = {RSP_ERR, 32'h0};
      rsp_cnt_ld = 3'd1;
    end else if (bus_ack) begin
      rsp_load   = 1'b1;
      rsp_data   = {RSP_OK, wbm_rdata_i[31:0]};
      rsp_cnt_ld = we_q ? 3'd1 : 3'd5;
    end else if (tmo_hit) begin
      rsp_load   = 1'b1;
      rsp_data   = {RSP_TO, 32'h0};
      rsp_cnt_ld = 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      cnt_q   <= 2'd0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_fire) begin
            if (rx_data_i == CMD_WR) begin
              we_q    <= 1'b1;
              state_q <= ST_ADDR;
            end else if (rx_data_i == CMD_RD) begin
              we_q    <= 1'b0;
              state_q <= ST_ADDR;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            addr_q <= {addr_q[AW-9:0], rx_data_i};
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (we_q) begin
                state_q <= ST_WDATA;
              end else begin
                state_q <= ST_BUS;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                sel_q   <= '1;
              end
            end
          end
        end
        ST_WDATA: begin
          if (rx_fire) begin
            wdata_q <= {wdata_q[DW-9:0], rx_data_i};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= ST_BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              sel_q   <= '1;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack || tmo_hit) begin
            state_q <= ST_RESP;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            sel_q   <= '0;
          end
        end
        ST_RESP: begin
          if (tx_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_addr_o  = addr_q;
  assign wbm_wdata_o = wdata_q;
  assign wbm_sel_o   = sel_q;

  wb_uart_bridge_rsp u_rsp (
    .clk         (clk),
    .rst         (rst),
    .load_i      (rsp_load),
    .load_data_i (rsp_data),
    .load_cnt_i  (rsp_cnt_ld),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .cnt_o       (rsp_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_bridge.sv
// tb_wb_uart_bridge: directed self-checking bench for wb_uart_bridge.
`default_nettype none

module tb_wb_uart_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] rdata = 32'h0;
  logic        ack = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  wb_uart_bridge dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_addr_o(addr), .wbm_wdata_o(wdata), .wbm_sel_o(sel),
    .wbm_rdata_i(rdata), .wbm_ack_i(ack), .busy_o(busy)
  );

  always @(posedge clk) if (cyc && stb && ack) ack_cnt <= ack_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin tick(); n++; end
    chk("rx_accept_bound", 64'(n < 100), 64'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] d);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic do_ack(input logic [31:0] rd);
    ack = 1'b1; rdata = rd;
    tick();
    ack = 1'b0; rdata = 32'h0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 100) begin tick(); n++; end
    chk({tag, "_valid"}, 64'(tx_valid), 64'd1);
    chk(tag, 64'(tx_data), 64'(exp));
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    int a0;
    int n;
    tick(); tick();
    // Reset state
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_cyc", 64'(cyc), 64'd0);
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // Stray ack in IDLE is ignored
    ack = 1'b1; tick(); ack = 1'b0; tick();
    chk("stray_ack_txv", 64'(tx_valid), 64'd0);
    chk("stray_ack_busy", 64'(busy), 64'd0);

    // 1: write
    a0 = ack_cnt;
    send_frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
    chk("w_cyc", 64'(cyc), 64'd1);
    chk("w_stb", 64'(stb), 64'd1);
    chk("w_we", 64'(we), 64'd1);
    chk("w_addr", 64'(addr), 64'h1000);
    chk("w_wdata", 64'(wdata), 64'hDEADBEEF);
    chk("w_sel", 64'(sel), 64'hF);
    chk("w_rx_ready", 64'(rx_ready), 64'd0);
    chk("w_busy", 64'(busy), 64'd1);
    tick();
    do_ack(32'h0);
    chk("w_cyc_drop", 64'(cyc), 64'd0);
    chk("w_stb_drop", 64'(stb), 64'd0);
    chk("w_ack_count", 64'(ack_cnt - a0), 64'd1);
    recv_byte("w_rsp0", 8'h4B);
    chk("w_idle_busy", 64'(busy), 64'd0);
    chk("w_idle_txv", 64'(tx_valid), 64'd0);

    // 2: read
    a0 = ack_cnt;
    send_frame(8'h52, 32'h0000_1004, 32'h0);
    chk("r_cyc", 64'(cyc), 64'd1);
    chk("r_we", 64'(we), 64'd0);
    chk("r_addr", 64'(addr), 64'h1004);
    do_ack(32'h1234_5678);
    chk("r_cyc_drop", 64'(cyc), 64'd0);
    chk("r_ack_count", 64'(ack_cnt - a0), 64'd1);
    recv_byte("r_rsp0", 8'h4B);
    recv_byte("r_rsp1", 8'h12);
    recv_byte("r_rsp2", 8'h34);
    recv_byte("r_rsp3", 8'h56);
    recv_byte("r_rsp4", 8'h78);
    chk("r_idle_busy", 64'(busy), 64'd0);

    // 3: unknown command, then a normal read
    a0 = ack_cnt;
    send_byte(8'hA5);
    chk("u_cyc", 64'(cyc), 64'd0);
    chk("u_txv", 64'(tx_valid), 64'd1);
    chk("u_rx_ready", 64'(rx_ready), 64'd0);
    recv_byte("u_rsp", 8'h3F);
    chk("u_busy", 64'(busy), 64'd0);
    send_frame(8'h52, 32'h0000_0008, 32'h0);
    chk("u2_addr", 64'(addr), 64'h8);
    do_ack(32'hCAFE_F00D);
    chk("u_ack_count", 64'(ack_cnt - a0), 64'd1);
    recv_byte("u2_rsp0", 8'h4B);
    recv_byte("u2_rsp1", 8'hCA);
    recv_byte("u2_rsp2", 8'hFE);
    recv_byte("u2_rsp3", 8'hF0);
    recv_byte("u2_rsp4", 8'h0D);

    // 4: tx back-pressure during a read response, with an rx byte pending
    send_frame(8'h52, 32'h0000_00F0, 32'h0);
    do_ack(32'hA1B2_C3D4);
    recv_byte("bp_rsp0", 8'h4B);
    rx_data = 8'h52; rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_txv", 64'(tx_valid), 64'd1);
      chk("bp_txd", 64'(tx_data), 64'hA1);
      chk("bp_rx_ready", 64'(rx_ready), 64'd0);
      tick();
    end
    rx_valid = 1'b0;
    recv_byte("bp_rsp1", 8'hA1);
    recv_byte("bp_rsp2", 8'hB2);
    recv_byte("bp_rsp3", 8'hC3);
    recv_byte("bp_rsp4", 8'hD4);
    chk("bp_busy", 64'(busy), 64'd0);

    // 5: reset while waiting in BUS
    send_frame(8'h52, 32'h0000_0010, 32'h0);
    tick(); tick(); tick();
    chk("rs_cyc_before", 64'(cyc), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_cyc", 64'(cyc), 64'd0);
    chk("rs_stb", 64'(stb), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_txv", 64'(tx_valid), 64'd0);
    chk("rs_rx_ready", 64'(rx_ready), 64'd1);
    send_frame(8'h57, 32'h0000_0020, 32'h0102_0304);
    chk("rs2_addr", 64'(addr), 64'h20);
    chk("rs2_wdata", 64'(wdata), 64'h01020304);
    do_ack(32'h0);
    recv_byte("rs2_rsp", 8'h4B);

    // 6: no ack
    send_frame(8'h52, 32'h0000_0030, 32'h0);
    chk("to_cyc", 64'(cyc), 64'd1);
    n = 0;
`ifdef WB_BRIDGE_TIMEOUT_EN
    while (cyc && n < 400) begin tick(); n++; end
    chk("to_cycles", 64'(n), 64'd255);
    recv_byte("to_rsp", 8'h54);
    chk("to_busy", 64'(busy), 64'd0);
`else
    while (cyc && n < 1000) begin tick(); n++; end
    chk("noto_cycles", 64'(n), 64'd1000);
    chk("noto_cyc", 64'(cyc), 64'd1);
    do_ack(32'h5555_AAAA);
    recv_byte("noto_rsp0", 8'h4B);
    recv_byte("noto_rsp1", 8'h55);
    recv_byte("noto_rsp2", 8'h55);
    recv_byte("noto_rsp3", 8'hAA);
    recv_byte("noto_rsp4", 8'hAA);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
